// File: rtl/mem_access_stage.sv
// Memory-access stage: latches E->M bus, aligns/extends SRAM load data, drives Writeback and Decode bypass.
// Latency 1 cycle; M_allowin = !M_valid | W_allowin, and SRAM rdata is buffered while Writeback stalls.
// Optional misaligned-load check (ale_excp) enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access_stage #(
    parameter int EM_BUS_WID = 74,
    parameter int MW_BUS_WID = 70,
    parameter int MD_FOR_WID = 37
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  W_allowin,
    output logic                  M_allowin,
    input  logic                  EM_valid,
    input  logic [EM_BUS_WID-1:0] EM_BUS,
    input  logic [31:0]           data_sram_rdata,
    output logic                  MW_valid,
    output logic [MW_BUS_WID-1:0] MW_BUS,
    output logic [MD_FOR_WID-1:0] MD_for_BUS,
    output logic                  ale_excp
);

    localparam logic [0:0] BUF_EMPTY = 1'b0;
    localparam logic [0:0] BUF_HELD  = 1'b1;

    logic                  m_valid_q, m_valid_d;
    logic [EM_BUS_WID-1:0] em_bus_q, em_bus_d;
    logic [31:0]           rdata_buf_q, rdata_buf_d;
    logic [0:0]            buf_state_q, buf_state_d;

    logic        m_allowin;
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic        gr_we;
    logic [4:0]  dest;
    logic [3:0]  res_from_mem;
    logic        is_load;
    logic        is_unsigned;
    logic [1:0]  ld_size;

    logic [31:0] ld_word;
    logic [31:0] ld_shift;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic [31:0] final_result;
    logic        ale;
    logic        wb_we;

    assign pc           = em_bus_q[73:42];
    assign alu_result   = em_bus_q[41:10];
    assign gr_we        = em_bus_q[9];
    assign dest         = em_bus_q[8:4];
    assign res_from_mem = em_bus_q[3:0];
    assign is_load      = res_from_mem[0];
    assign ld_size      = res_from_mem[2:1];
    assign is_unsigned  = res_from_mem[3];

    always_comb begin
        m_allowin = !m_valid_q | W_allowin;
        m_valid_d = m_allowin ? EM_valid : m_valid_q;
        em_bus_d  = (EM_valid & m_allowin) ? EM_BUS : em_bus_q;
    end

    // The buffer only fills on the first stalled cycle of a load and is frozen until Writeback drains it.
    always_comb begin
        buf_state_d = buf_state_q;
        rdata_buf_d = rdata_buf_q;
        case (buf_state_q)
            BUF_EMPTY: begin
                if (m_valid_q & is_load & !W_allowin) begin
                    buf_state_d = BUF_HELD;
                    rdata_buf_d = data_sram_rdata;
                end
            end
            BUF_HELD: begin
                if (W_allowin) begin
                    buf_state_d = BUF_EMPTY;
                end
            end
            default: buf_state_d = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            m_valid_q   <= 1'b0;
            em_bus_q    <= '0;
            rdata_buf_q <= '0;
            buf_state_q <= BUF_EMPTY;
        end else begin
            m_valid_q   <= m_valid_d;
            em_bus_q    <= em_bus_d;
            rdata_buf_q <= rdata_buf_d;
            buf_state_q <= buf_state_d;
        end
    end

    always_comb begin
        ld_word  = (buf_state_q == BUF_HELD) ? rdata_buf_q : data_sram_rdata;
        ld_shift = ld_word >> {alu_result[1:0], 3'b000};
        ld_byte  = ld_shift[7:0];
        ld_half  = alu_result[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_size)
            2'b00:   ld_ext = {{24{!is_unsigned & ld_byte[7]}}, ld_byte};
            2'b01:   ld_ext = {{16{!is_unsigned & ld_half[15]}}, ld_half};
            default: ld_ext = ld_word;
        endcase
        final_result = is_load ? ld_ext : alu_result;
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = ((ld_size == 2'b01) & alu_result[0])
                      | (ld_size[1] & (alu_result[1:0] != 2'b00));
    assign ale = m_valid_q & is_load & misaligned;
`else
    assign ale = 1'b0;
`endif

    // A faulting load must not retire a register write nor feed the bypass.
    assign wb_we = gr_we & !ale;

    assign M_allowin  = m_allowin;
    assign MW_valid   = m_valid_q;
    assign MW_BUS     = {pc, final_result, wb_we, dest};
    assign MD_for_BUS = {dest & {5{m_valid_q & wb_we}}, final_result};
    assign ale_excp   = ale;

endmodule
